keypad_scanner: RTL

//  Front end for the player's 4x4 hex keypad (Pmod KYPD).
//  - Drives the keypad columns one at a time, samples the rows and decodes the hex key.
//  - Debounces across whole scans.
//  - Produces keyValue/keyPressed for vga_controller, which judges note hits from them.
//  - Single clock domain; replaces raw, bouncy switch inputs to the game logic.

---
 rtl/keypad_scanner.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: drives columns one-hot low, synchronizes rows,
// decodes the first key per full scan and debounces across whole scans.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] keyValue,
    output logic       keyPressed,
    output logic       keyStrobe
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

    logic [3:0]    r_rowMeta, r_rowS;
    logic [DW-1:0] r_divCnt;
    logic [1:0]    r_colIdx;
    logic          r_scanHit;
    logic [3:0]    r_scanCode;
    state_t        r_state;
    logic [3:0]    r_cand, r_keyValue;
    logic [CW-1:0] r_cnt;
    logic          r_keyPressed, r_keyStrobe;

    logic          w_term, w_scanEnd, w_colHit, w_hit, w_same;
    logic [1:0]    w_rowIdx;
    logic [3:0]    w_colCode, w_code;
    logic [CW-1:0] w_cntInc;
    state_t        w_stateNext;
    logic [3:0]    w_candNext, w_valueNext;
    logic [CW-1:0] w_cntNext;
    logic          w_pressedNext, w_strobeNext;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
            4'hC: key_code = 4'h0;  4'hD: key_code = 4'hF;
            4'hE: key_code = 4'hE;  default: key_code = 4'hD;
        endcase
    endfunction

    assign w_term    = (r_divCnt == DIV_LAST);
    assign w_scanEnd = w_term && (r_colIdx == 2'd3);
    assign w_colHit  = ~&r_rowS;

    // Lowest active-low row wins within a column.
    always_comb begin
        w_rowIdx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!r_rowS[r]) w_rowIdx = 2'(r);
        end
    end

    assign w_colCode = key_code(w_rowIdx, r_colIdx);
    // An earlier column already latched in this scan takes priority.
    assign w_hit     = r_scanHit | w_colHit;
    assign w_code    = r_scanHit ? r_scanCode : w_colCode;
    assign w_same    = w_hit && (w_code == r_cand);
    assign w_cntInc  = r_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rowMeta  <= 4'hF;
            r_rowS     <= 4'hF;
            r_divCnt   <= '0;
            r_colIdx   <= 2'd0;
            r_scanHit  <= 1'b0;
            r_scanCode <= 4'h0;
        end else begin
            r_rowMeta <= row;
            r_rowS    <= r_rowMeta;
            if (w_term) begin
                r_divCnt <= '0;
                r_colIdx <= r_colIdx + 2'd1;
                if (w_scanEnd) begin
                    r_scanHit  <= 1'b0;
                    r_scanCode <= 4'h0;
                end else if (!r_scanHit && w_colHit) begin
                    r_scanHit  <= 1'b1;
                    r_scanCode <= w_colCode;
                end
            end else begin
                r_divCnt <= r_divCnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_candNext    = r_cand;
        w_cntNext     = r_cnt;
        w_valueNext   = r_keyValue;
        w_pressedNext = r_keyPressed;
        w_strobeNext  = 1'b0;
        if (w_scanEnd) begin
            case (r_state)
                IDLE: if (w_hit) begin
                    w_stateNext = CONFIRM;
                    w_candNext  = w_code;
                    w_cntNext   = CNT_ONE;
                end
                CONFIRM: if (w_same) begin
                    if (w_cntInc == CNT_DONE) begin
                        w_stateNext   = HELD;
                        w_cntNext     = '0;
                        w_valueNext   = r_cand;
                        w_pressedNext = 1'b1;
                        w_strobeNext  = 1'b1;
                    end else begin
                        w_cntNext = w_cntInc;
                    end
                end else if (w_hit) begin
                    w_candNext = w_code;
                    w_cntNext  = CNT_ONE;
                end else begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end
                HELD: if (!w_same) begin
                    w_stateNext = RELEASE;
                    w_cntNext   = CNT_ONE;
                end
                RELEASE: if (w_same) begin
                    w_stateNext = HELD;
                    w_cntNext   = '0;
                end else if (w_cntInc == CNT_DONE) begin
                    w_stateNext   = IDLE;
                    w_cntNext     = '0;
                    w_pressedNext = 1'b0;
                end else begin
                    w_cntNext = w_cntInc;
                end
                default: w_stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cand       <= 4'h0;
            r_cnt        <= '0;
            r_keyValue   <= 4'h0;
            r_keyPressed <= 1'b0;
            r_keyStrobe  <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_cand       <= w_candNext;
            r_cnt        <= w_cntNext;
            r_keyValue   <= w_valueNext;
            r_keyPressed <= w_pressedNext;
            r_keyStrobe  <= w_strobeNext;
        end
    end

    assign col        = ~(4'b0001 << r_colIdx);
    assign keyValue   = r_keyValue;
    assign keyPressed = r_keyPressed;
    assign keyStrobe  = r_keyStrobe;
endmodule
